// File: rtl/rename_regfile_pkg.sv
// rename_regfile_pkg: shared constants and helpers for the rename register file.
// Holds the default widths (RBID = reorder tag bits, RLEN = register data bits),
// the TRUE/FALSE constants and a popcount helper for the busy counter.
package rename_regfile_pkg;

  localparam int TRUE  = 1;
  localparam int FALSE = 0;

  localparam int RBID  = 4;   // reorder tag width, 16-entry ROB
  localparam int RLEN  = 32;  // architectural register width
  localparam int NREG  = 32;

  function automatic logic [5:0] popcnt32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one source-operand query port of the rename register file.
// Combinational: selects the architectural value when not busy, else the pending
// tag zero-extended; x0 always reads ready/0. Ports: i_addr, i_busy, i_tag, i_val
// (state of the addressed register), i_cmt_hit/i_cmt_val (same-cycle clearing
// commit to this register), o_ready, o_val.
// Optional feature macro: COMMIT_BYPASS_EN forwards a same-cycle clearing commit.
import rename_regfile_pkg::*;

module regfile_rdport #(
  parameter int XLEN  = RLEN,
  parameter int TAG_W = RBID
) (
  input  logic [4:0]       i_addr,
  input  logic             i_busy,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [XLEN-1:0]  i_val,
  input  logic             i_cmt_hit,
  input  logic [XLEN-1:0]  i_cmt_val,
  output logic             o_ready,
  output logic [XLEN-1:0]  o_val
);

`ifndef COMMIT_BYPASS_EN
  // Commit forwarding is compiled out; these inputs only exist for a uniform port list.
  wire unused_bypass = &{1'b0, i_cmt_hit, i_cmt_val};
`endif

  always_comb begin
    o_ready = 1'b1;
    o_val   = i_val;
    if (i_addr == 5'd0) begin
      o_ready = 1'b1;
      o_val   = '0;
    end
`ifdef COMMIT_BYPASS_EN
    else if (i_cmt_hit) begin
      o_ready = 1'b1;
      o_val   = i_cmt_val;
    end
`endif
    else if (i_busy) begin
      o_ready = 1'b0;
      o_val   = {{(XLEN-TAG_W){1'b0}}, i_tag};
    end
  end

endmodule

// File: rtl/rename_regfile.sv
// rename_regfile: 32-entry architectural register file with per-register busy bit
// and reorder tag for register renaming. Ports: clk, rst (async active-low), rdy
// (global stall), rs1/rs2 query ports, rename (rd_in_fg/rd_idxin_update/
// reorder_rear), commit (rd_out_fg/rd_idxout_update/rd_val_update/reorder_front),
// flush, busy_cnt. Optional feature macro: COMMIT_BYPASS_EN (see regfile_rdport).
import rename_regfile_pkg::*;

module rename_regfile #(
  parameter int XLEN  = RLEN,
  parameter int TAG_W = RBID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_ready,
  output logic             rs2_ready,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  input  logic             rd_in_fg,
  input  logic [4:0]       rd_idxin_update,
  input  logic [TAG_W-1:0] reorder_rear,
  input  logic             rd_out_fg,
  input  logic [4:0]       rd_idxout_update,
  input  logic [XLEN-1:0]  rd_val_update,
  input  logic [TAG_W-1:0] reorder_front,
  input  logic             flush,
  output logic [5:0]       busy_cnt
);

  logic [XLEN-1:0]  r_val [NREG];
  logic [TAG_W-1:0] r_tag [NREG];
  logic [31:0]      r_busy;
  logic [5:0]       r_busy_cnt;

  logic        w_ren;
  logic        w_cmt;
  logic        w_cmt_clr;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic [31:0] w_busy_nxt;

  assign w_ren = rdy & rd_in_fg  & (rd_idxin_update  != 5'd0);
  assign w_cmt = rdy & rd_out_fg & (rd_idxout_update != 5'd0);
  // A commit retires the mapping only if it is still the youngest one and no
  // younger rename of the same register lands on this very edge.
  assign w_cmt_clr = w_cmt & (r_tag[rd_idxout_update] == reorder_front) &
                     ~(w_ren & (rd_idxin_update == rd_idxout_update));

  assign w_rs1_hit = w_cmt_clr & (rs1_addr == rd_idxout_update);
  assign w_rs2_hit = w_cmt_clr & (rs2_addr == rd_idxout_update);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_cmt_clr) w_busy_nxt[rd_idxout_update] = 1'b0;
    if (w_ren)     w_busy_nxt[rd_idxin_update]  = 1'b1;
    if (rdy & flush) w_busy_nxt = '0;   // flush wins over a same-cycle rename
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_val[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (rdy) begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= popcnt32(w_busy_nxt);
      if (w_ren) r_tag[rd_idxin_update]  <= reorder_rear;
      if (w_cmt) r_val[rd_idxout_update] <= rd_val_update;
    end
  end

  assign busy_cnt = r_busy_cnt;

  regfile_rdport #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs1 (
    .i_addr    (rs1_addr),
    .i_busy    (r_busy[rs1_addr]),
    .i_tag     (r_tag[rs1_addr]),
    .i_val     (r_val[rs1_addr]),
    .i_cmt_hit (w_rs1_hit),
    .i_cmt_val (rd_val_update),
    .o_ready   (rs1_ready),
    .o_val     (rs1_val)
  );

  regfile_rdport #(.XLEN(XLEN), .TAG_W(TAG_W)) u_rs2 (
    .i_addr    (rs2_addr),
    .i_busy    (r_busy[rs2_addr]),
    .i_tag     (r_tag[rs2_addr]),
    .i_val     (r_val[rs2_addr]),
    .i_cmt_hit (w_rs2_hit),
    .i_cmt_val (rd_val_update),
    .o_ready   (rs2_ready),
    .o_val     (rs2_val)
  );

endmodule

// File: doc/rename_regfile.md
RENAME_REGFILE -- requirements
Module: rename_regfile

Interface
REQ-001 Parameter XLEN, default 32: register data width.
REQ-002 Parameter TAG_W, default 4: reorder tag width, matching the 16-entry ROB.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rdy  input  1  global ready; when low, no state changes.
REQ-006 rs1_addr, rs2_addr  input  5  source register query addresses.
REQ-007 rs1_ready, rs2_ready  output  1  source value is architectural (not pending).
REQ-008 rs1_val, rs2_val  output  XLEN  register value if ready, else the pending reorder tag zero-extended.
REQ-009 rd_in_fg  input  1  rename request.
REQ-010 rd_idxin_update  input  5  register being renamed.
REQ-011 reorder_rear  input  TAG_W  tag assigned on rename.
REQ-012 rd_out_fg  input  1  commit request.
REQ-013 rd_idxout_update  input  5  committed register.
REQ-014 rd_val_update  input  XLEN  committed value.
REQ-015 reorder_front  input  TAG_W  tag of the committing entry.
REQ-016 flush  input  1  misprediction clear of all pending tags.
REQ-017 busy_cnt  output  6  registered count of busy registers.

Function
REQ-018 Per register: value[XLEN], busy, tag[TAG_W]; x0 is always value 0 and never busy.
REQ-019 Query path is combinational: if !busy[a] -> ready=1, val=value[a]; else ready=0, val={zeros,tag[a]}; a=0 -> ready=1, val=0.
REQ-020 A query reflects state before this edge's rename, so rs==rd in the renaming instruction returns the older mapping.
REQ-021 Rename (rdy & rd_in_fg & rd!=0) SHALL set busy[rd]=1 and tag[rd]=reorder_rear on the next edge; rename to x0 is ignored.
REQ-022 Commit (rdy & rd_out_fg & rd!=0) SHALL write value[rd]=rd_val_update unconditionally.
REQ-023 Commit clears busy[rd] only if tag[rd]==reorder_front and there is no same-cycle rename of that rd.
REQ-024 Same-cycle rename and commit of one register: value is written, busy stays 1, tag becomes reorder_rear.
REQ-025 Flush SHALL clear every busy bit on the next edge, overriding a same-cycle rename; a same-cycle commit still writes its value.
REQ-026 busy_cnt SHALL equal the popcount of busy bits after each edge and is always <=31.
REQ-027 With rdy low, rename, commit and flush are all ignored; query outputs remain combinational.

Reset
REQ-028 rst low SHALL immediately set all value=0, busy=0, tag=0 and busy_cnt=0, regardless of clk.
REQ-029 Reset asserted mid-operation SHALL discard pending renames; the first edge after release performs normal operation.

Configuration
REQ-030 COMMIT_BYPASS_EN defined: a query hitting a register with a same-cycle matching commit (per REQ-023) returns ready=1 and val=rd_val_update combinationally.
REQ-031 COMMIT_BYPASS_EN undefined: the query reflects registered state only, and the committed value is visible one cycle later.

Structure
REQ-032 TAG_W and XLEN defaults, the True/False constants, and the RBID/RLEN width macros SHALL come from the shared defines.v; no local redefinition.
REQ-033 One sub-module, regfile_rdport (query mux plus optional bypass), SHALL be instantiated twice, once for rs1 and once for rs2.

Verification
REQ-034 Reset, then query x5 -> rs1_ready=1, rs1_val=0, busy_cnt=0.
REQ-035 Rename x5 tag 3; next cycle query x5 -> ready=0, val=3; commit x5 tag 3 val 0xDEADBEEF -> next cycle ready=1, val=0xDEADBEEF, busy_cnt=0.
REQ-036 Rename x7 tag 2, then rename x7 tag 9; commit x7 tag 2 val 0x11 -> value=0x11, still busy, query val=9.
REQ-037 Same cycle: rename x4 tag 6 and commit x4 tag 1 val 0x22 -> busy=1, tag=6, busy_cnt unchanged plus one if x4 was not busy.
REQ-038 Rename x1..x3, then flush with a same-cycle rename of x8 -> all ready, busy_cnt=0; rename/commit/query on x0 -> always ready, val 0.
REQ-039 With COMMIT_BYPASS_EN, query x5 during its matching commit of 0x55 -> ready=1, val=0x55 in the same cycle; without it, ready=0 that cycle.
